// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard control for a 5-stage pipeline.
// Define FWD_BYPASS_EN for EX/MEM and MEM/WB bypassing; otherwise dependent instructions stall.
module forward_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        stall,
    output logic [15:0] stall_cnt
);

    logic       idex_valid, idex_regwrite, idex_memread;
    logic [4:0] idex_rs, idex_rt, idex_rd;
    logic       exmem_valid, exmem_regwrite, exmem_memread;
    logic [4:0] exmem_rd;
    logic       memwb_valid, memwb_regwrite;
    logic [4:0] memwb_rd;

    logic idex_wr, exmem_wr, memwb_wr;

    assign idex_wr  = idex_valid  && idex_regwrite  && (idex_rd  != 5'd0);
    assign exmem_wr = exmem_valid && exmem_regwrite && (exmem_rd != 5'd0);
    assign memwb_wr = memwb_valid && memwb_regwrite && (memwb_rd != 5'd0);

`ifdef FWD_BYPASS_EN
    always_comb begin
        fwd_a = 2'd0;
        fwd_b = 2'd0;
        if (idex_valid) begin
            if (exmem_wr && exmem_rd == idex_rs)      fwd_a = 2'd2;
            else if (memwb_wr && memwb_rd == idex_rs) fwd_a = 2'd1;
            if (exmem_wr && exmem_rd == idex_rt)      fwd_b = 2'd2;
            else if (memwb_wr && memwb_rd == idex_rt) fwd_b = 2'd1;
        end
    end

    always_comb begin
        stall = id_valid && idex_wr && idex_memread &&
                (idex_rd == id_rs || idex_rd == id_rt);
    end
`else
    assign fwd_a = 2'd0;
    assign fwd_b = 2'd0;

    // Without bypass, any producer still in EX or MEM must drain before use.
    always_comb begin
        stall = id_valid &&
                ((idex_wr  && (idex_rd  == id_rs || idex_rd  == id_rt)) ||
                 (exmem_wr && (exmem_rd == id_rs || exmem_rd == id_rt)));
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_valid     <= 1'b0;
            idex_regwrite  <= 1'b0;
            idex_memread   <= 1'b0;
            idex_rs        <= '0;
            idex_rt        <= '0;
            idex_rd        <= '0;
            exmem_valid    <= 1'b0;
            exmem_regwrite <= 1'b0;
            exmem_memread  <= 1'b0;
            exmem_rd       <= '0;
            memwb_valid    <= 1'b0;
            memwb_regwrite <= 1'b0;
            memwb_rd       <= '0;
            stall_cnt      <= '0;
        end else begin
            idex_rs <= id_rs;
            idex_rt <= id_rt;
            idex_rd <= id_rd;
            if (id_valid && !stall && !flush) begin
                idex_valid    <= 1'b1;
                idex_regwrite <= id_regwrite;
                idex_memread  <= id_memread;
            end else begin
                idex_valid    <= 1'b0;
                idex_regwrite <= 1'b0;
                idex_memread  <= 1'b0;
            end
            exmem_valid    <= idex_valid;
            exmem_regwrite <= idex_regwrite;
            exmem_memread  <= idex_memread;
            exmem_rd       <= idex_rd;
            memwb_valid    <= exmem_valid;
            memwb_regwrite <= exmem_regwrite;
            memwb_rd       <= exmem_rd;
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed bench for forward_ctrl; covers the default build and, when FWD_BYPASS_EN is defined, the bypass build.
module tb_forward_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_regwrite, id_memread, flush;
    logic [1:0]  fwd_a, fwd_b;
    logic        stall;
    logic [15:0] stall_cnt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned exp_cnt  = 0;

    forward_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall       (stall),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_in(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        flush       = fl;
    endtask

    task automatic nop();
        id_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        nop();
        repeat (4) tick();
    endtask

    initial begin
        nop();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_fwd_a", fwd_a, 0);
        check("rst_fwd_b", fwd_b, 0);
        check("rst_stall", stall, 0);
        check("rst_cnt", stall_cnt, 0);

`ifdef FWD_BYPASS_EN
        // lw r2 ; add r8,r2,r2
        id_in(1, 1, 0, 2, 1, 1, 0); tick();
        id_in(1, 2, 2, 8, 1, 0, 0); #1;
        check("lu_stall1", stall, 1);
        tick(); exp_cnt++;
        #1;
        check("lu_stall2", stall, 0);
        check("lu_bubble_fa", fwd_a, 0);
        check("lu_cnt", stall_cnt, exp_cnt);
        tick();
        nop(); #1;
        check("lu_fa", fwd_a, 1);
        check("lu_fb", fwd_b, 1);
        drain();

        // add r3 ; sub r4,r3,r5
        id_in(1, 1, 2, 3, 1, 0, 0); tick();
        id_in(1, 3, 5, 4, 1, 0, 0); #1;
        check("b2b_stall", stall, 0);
        tick();
        nop(); #1;
        check("b2b_fa", fwd_a, 2);
        check("b2b_fb", fwd_b, 0);
        drain();

        // add r3 ; nop ; or r6,r7,r3
        id_in(1, 1, 2, 3, 1, 0, 0); tick();
        nop(); tick();
        id_in(1, 7, 3, 6, 1, 0, 0); tick();
        nop(); #1;
        check("wb_fb", fwd_b, 1);
        check("wb_fa", fwd_a, 0);
        drain();

        // add r3 ; add r3 ; use r3 twice
        id_in(1, 1, 2, 3, 1, 0, 0); tick();
        id_in(1, 4, 5, 3, 1, 0, 0); tick();
        id_in(1, 3, 3, 9, 1, 0, 0); tick();
        nop(); #1;
        check("prio_fa", fwd_a, 2);
        check("prio_fb", fwd_b, 2);
        drain();

        // writer to r0 then use r0
        id_in(1, 1, 2, 0, 1, 1, 0); tick();
        id_in(1, 0, 0, 5, 1, 0, 0); #1;
        check("r0_stall", stall, 0);
        tick();
        nop(); #1;
        check("r0_fa", fwd_a, 0);
        drain();

        // flushed add r3, then use r3
        id_in(1, 1, 2, 3, 1, 0, 1); tick();
        id_in(1, 3, 0, 6, 1, 0, 0); tick();
        nop(); #1;
        check("flush_fa", fwd_a, 0);
        drain();

        // load in MEM/WB never stalls
        id_in(1, 1, 0, 2, 1, 1, 0); tick();
        nop(); tick();
        id_in(1, 2, 0, 6, 1, 0, 0); #1;
        check("wbload_stall", stall, 0);
        tick();
        nop(); #1;
        check("wbload_fa", fwd_a, 1);
        drain();

        // flush together with a load-use stall
        id_in(1, 1, 0, 2, 1, 1, 0); tick();
        id_in(1, 2, 0, 6, 1, 0, 1); #1;
        check("fs_stall", stall, 1);
        tick(); exp_cnt++;
        id_in(1, 2, 0, 6, 1, 0, 0); #1;
        check("fs_after", stall, 0);
        check("fs_cnt", stall_cnt, exp_cnt);
        drain();
`else
        // add r3 ; sub r4,r3,r5 stalls twice with no forwarding
        id_in(1, 1, 2, 3, 1, 0, 0); #1;
        check("dep_id_stall", stall, 0);
        tick();
        id_in(1, 3, 5, 4, 1, 0, 0); #1;
        check("dep_stall1", stall, 1);
        check("dep_fa1", fwd_a, 0);
        tick(); exp_cnt++;
        #1;
        check("dep_stall2", stall, 1);
        check("dep_fa2", fwd_a, 0);
        tick(); exp_cnt++;
        #1;
        check("dep_stall3", stall, 0);
        tick();
        nop(); #1;
        check("dep_fa_ex", fwd_a, 0);
        check("dep_fb_ex", fwd_b, 0);
        check("dep_cnt", stall_cnt, exp_cnt);
        drain();

        // producer in MEM/WB never stalls
        id_in(1, 1, 2, 3, 1, 0, 0); tick();
        nop(); tick();
        nop(); tick();
        id_in(1, 3, 0, 9, 1, 0, 0); #1;
        check("wb_stall", stall, 0);
        drain();

        // writer to r0 then use r0
        id_in(1, 1, 2, 0, 1, 0, 0); tick();
        id_in(1, 0, 0, 5, 1, 0, 0); #1;
        check("r0_stall", stall, 0);
        drain();

        // flushed add r3, then use r3
        id_in(1, 1, 2, 3, 1, 0, 1); tick();
        id_in(1, 3, 3, 6, 0, 0, 0); #1;
        check("flush_stall", stall, 0);
        drain();

        // matching operands but no valid instruction in ID
        id_in(1, 1, 2, 3, 1, 0, 0); tick();
        id_in(0, 3, 3, 6, 1, 0, 0); #1;
        check("novalid_stall", stall, 0);
        drain();

        // flush together with a stall still counts
        id_in(1, 1, 2, 3, 1, 0, 0); tick();
        id_in(1, 3, 0, 7, 1, 0, 1); #1;
        check("fs_stall1", stall, 1);
        tick(); exp_cnt++;
        id_in(1, 3, 0, 7, 1, 0, 0); #1;
        check("fs_stall2", stall, 1);
        check("fs_cnt1", stall_cnt, exp_cnt);
        tick(); exp_cnt++;
        #1;
        check("fs_clear", stall, 0);
        check("fs_cnt2", stall_cnt, exp_cnt);
        drain();

        // load-use also stalls twice here
        id_in(1, 1, 0, 2, 1, 1, 0); tick();
        id_in(1, 2, 2, 8, 1, 0, 0); #1;
        check("lu_stall1", stall, 1);
        tick(); exp_cnt++;
        #1;
        check("lu_stall2", stall, 1);
        tick(); exp_cnt++;
        #1;
        check("lu_clear", stall, 0);
        check("lu_cnt", stall_cnt, exp_cnt);
        drain();
`endif

        // reset in the middle of a load-use stall
        id_in(1, 1, 0, 2, 1, 1, 0); tick();
        id_in(1, 2, 2, 8, 1, 0, 0); #1;
        check("mrst_pre", stall, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        exp_cnt = 0;
        check("mrst_stall", stall, 0);
        check("mrst_cnt", stall_cnt, exp_cnt);
        check("mrst_fa", fwd_a, 0);
        check("mrst_fb", fwd_b, 0);
        drain();

        // counter saturation under a forced stall
        force dut.stall = 1'b1;
        repeat (100) tick();
        check("sat_cnt100", stall_cnt, 100);
        repeat (69900) tick();
        check("sat_cnt", stall_cnt, 16'hFFFF);
        release dut.stall;
        nop();
        tick();
        tick();
        check("sat_hold", stall_cnt, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/forward_ctrl.md
FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 id_valid  input  1  ID-stage instruction present this cycle.
REQ-004 id_rs  input  5  ID source register 1.
REQ-005 id_rt  input  5  ID source register 2.
REQ-006 id_rd  input  5  ID destination register, already resolved rd/rt.
REQ-007 id_regwrite  input  1  ID instruction writes the register file.
REQ-008 id_memread  input  1  ID instruction is a load.
REQ-009 flush  input  1  squash instruction entering ID/EX this cycle.
REQ-010 fwd_a  output  2  EX operand-A 3:1 mux select: 0 = regfile, 1 = MEM/WB result, 2 = EX/MEM result.
REQ-011 fwd_b  output  2  EX operand-B select, same encoding as fwd_a.
REQ-012 stall  output  1  hold PC and IF/ID; forward_ctrl inserts a bubble into ID/EX.
REQ-013 stall_cnt  output  16  count of stall cycles since reset.

Function
REQ-014 Internal stage records SHALL be ID/EX {valid, rs, rt, rd, regwrite, memread}, EX/MEM {valid, rd, regwrite, memread} and MEM/WB {valid, rd, regwrite}; each record advances one stage per clock, with no enable.
REQ-015 ID/EX SHALL load the ID inputs when id_valid=1 and stall=0 and flush=0; otherwise it SHALL load a bubble (valid=0, regwrite=0, memread=0).
REQ-016 A stage record SHALL count as a writer only when valid=1, regwrite=1 and rd!=0; register 0 SHALL never match.
REQ-017 fwd_a SHALL be 2 when the EX/MEM writer rd equals ID/EX rs, else 1 when the MEM/WB writer rd equals ID/EX rs, else 0; EX/MEM has priority when both match.
REQ-018 fwd_b SHALL follow REQ-017 using ID/EX rt.
REQ-019 fwd_a and fwd_b SHALL be 0 when ID/EX valid=0 and SHALL never take the value 3.
REQ-020 fwd_a, fwd_b and stall SHALL be combinational from the stage records and ID inputs: an instruction accepted at edge n sees its selects during cycle n+1.
REQ-021 Load-use: stall SHALL be 1 when id_valid=1 and the ID/EX record is a writer with memread=1 whose rd equals id_rs or id_rt.
REQ-022 Stall then holds for exactly one cycle per load-use pair, because the bubble clears the hazard on the next edge.
REQ-023 flush and stall asserted together: a bubble SHALL enter ID/EX, stall SHALL still be reported, and stall_cnt SHALL increment.
REQ-024 stall_cnt SHALL increment on every edge where stall=1 and SHALL saturate at 16'hFFFF.
REQ-025 The register file is write-first-half/read-second-half, so a MEM/WB writer SHALL never cause a stall.

Reset
REQ-026 With reset=1 at an edge, all stage records SHALL go to bubble and stall_cnt SHALL go to 0, overriding id_valid, flush and stall.
REQ-027 Reset behaviour SHALL be identical when asserted mid-stream, including during a stall.
REQ-028 In the cycle after reset: fwd_a=0, fwd_b=0, stall=0 and stall_cnt=0.

Configuration
REQ-029 Macro FWD_BYPASS_EN: when defined, the block SHALL behave as in REQ-017 to REQ-021.
REQ-030 When FWD_BYPASS_EN is undefined:
- fwd_a and fwd_b SHALL be tied to 0.
- stall SHALL be 1 whenever id_valid=1 and id_rs or id_rt matches the rd of an ID/EX or EX/MEM writer, loads or not.

Verification
REQ-031 add r3 then sub r4,r3,r5 back-to-back: expect fwd_a=2 in the sub EX cycle, stall never asserted.
REQ-032 add r3, nop, then or r6,r7,r3: expect fwd_b=1 in the or EX cycle; add r3 then add r3 then use r3: expect fwd=2 (priority).
REQ-033 lw r2 then add r8,r2,r2: expect stall=1 for exactly one cycle, a bubble in ID/EX, then fwd_a=fwd_b=1, and stall_cnt=1.
REQ-034 Writer to r0 followed by use of r0: expect fwd_a=0 and stall=0; flush on an add r3, then use r3: expect fwd_a=0.
REQ-035 Reset pulsed during a load-use stall: expect stall=0, stall_cnt=0 and fwd=0 the next cycle; 70000 forced stalls: expect stall_cnt=16'hFFFF.
REQ-036 FWD_BYPASS_EN undefined, add r3 then use r3: expect stall=1 for two cycles and fwd_a=0 throughout.
